// File: rtl/rdy_vld_dispatch.sv
// Multi-channel ready/valid dispatcher: one input stream routed by destination
// (or broadcast) into per-channel FIFOs, each drained by its own consumer.
module rdy_vld_dispatch #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int DEST_W   = 4,
    parameter bit BCAST_EN = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  logic [DATA_W-1:0]                     in_data,
    input  logic [DEST_W-1:0]                     in_dest,
    input  logic                                  in_bcast,
    output logic [NUM_CH-1:0]                     out_vld,
    input  logic [NUM_CH-1:0]                     out_rdy,
    output logic [NUM_CH*DATA_W-1:0]              out_data,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   ch_level,
    output logic                                  drop_err,
    output logic [15:0]                           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [DEST_W:0]   NUM_CH_D  = (DEST_W + 1)'(NUM_CH);

    logic [DATA_W-1:0] mem_r    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_r [NUM_CH];
    logic [LVL_W-1:0]  level_r  [NUM_CH];

    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] dest_hit_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic              bcast_s;
    logic              dest_ok_s;
    logic              in_rdy_s;
    logic              accept_s;
    logic              drop_s;
    logic              drop_err_r;
    logic [15:0]       drop_cnt_r;

    // Per-channel status decode from the occupancy registers
    always_comb begin
        full_s     = {NUM_CH{1'b0}};
        empty_s    = {NUM_CH{1'b0}};
        dest_hit_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            full_s[i]     = (level_r[i] == FULL_LVL);
            empty_s[i]    = (level_r[i] == {LVL_W{1'b0}});
            dest_hit_s[i] = (in_dest == DEST_W'(i));
        end
    end

    // Input acceptance: full is judged on pre-pop occupancy, never on in_vld
    always_comb begin
        bcast_s   = BCAST_EN & in_bcast;
        dest_ok_s = ({1'b0, in_dest} < NUM_CH_D);
        if (rst) begin
            in_rdy_s = 1'b0;
        end else if (bcast_s) begin
            in_rdy_s = ~(|full_s);
        end else if (dest_ok_s) begin
            in_rdy_s = ~(|(full_s & dest_hit_s));
        end else begin
            in_rdy_s = 1'b1;
        end
    end

    // Push/pop/drop strobes for this cycle
    always_comb begin
        accept_s = in_vld & in_rdy_s;
        drop_s   = accept_s & ~bcast_s & ~dest_ok_s;
        push_s   = {NUM_CH{1'b0}};
        pop_s    = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            push_s[i] = accept_s & (bcast_s | dest_hit_s[i]);
            pop_s[i]  = ~empty_s[i] & out_rdy[i];
        end
    end

    // FIFO storage; no reset needed since contents are only read while occupied
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= in_data;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_r[i] <= {PTR_W{1'b0}};
                rd_ptr_r[i] <= {PTR_W{1'b0}};
                level_r[i]  <= {LVL_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   level_r[i] <= level_r[i] + LVL_W'(1);
                    2'b01:   level_r[i] <= level_r[i] - LVL_W'(1);
                    default: level_r[i] <= level_r[i];
                endcase
            end
        end
    end

    // Illegal-destination drop pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_err_r <= 1'b0;
            drop_cnt_r <= 16'h0000;
        end else begin
            drop_err_r <= drop_s;
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
        end
    end

    assign in_rdy   = in_rdy_s;
    assign out_vld  = ~empty_s;
    assign drop_err = drop_err_r;
    assign drop_cnt = drop_cnt_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = mem_r[g][rd_ptr_r[g]];
        assign ch_level[g*LVL_W +: LVL_W]   = level_r[g];
    end

endmodule
